cpu_exec_sequencer: RTL and testbench

- Sits in the CCLK domain between the core-controller register interface and the CPU core.
- Generates CEXEC, the per-cycle execute enable of the single-cycle core, from RUN / STOP / STEP commands.
- Halts the core on a PC breakpoint and counts executed cycles for debug readback.
- Commands arrive already synchronised to CCLK over a valid/ready handshake.

---
 rtl/cpu_exec_sequencer.sv | 139 +++++++++++++
 tb/tb_cpu_exec_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_exec_sequencer.sv
// Execute-enable sequencer for the single-cycle core: RUN/STOP/STEP control,
// PC breakpoint halt and a saturating executed-cycle counter.
module cpu_exec_sequencer #(
  parameter int STEP_WIDTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  CCLK,
  input  logic                  CRST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [1:0]            CMD_OP,
  input  logic [STEP_WIDTH-1:0] CMD_ARG,
  input  logic                  BRK_EN,
  input  logic [31:0]           BRK_ADDR,
  input  logic [31:0]           REGPC,
  output logic                  CEXEC,
  output logic                  BUSY,
  output logic [1:0]            HALT_CAUSE,
  output logic [STEP_WIDTH-1:0] STEP_REM,
  output logic [CNT_WIDTH-1:0]  EXEC_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_t;

  localparam logic [1:0] OP_STOP   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_CLRCNT = 2'b11;

  localparam logic [1:0] HC_NONE = 2'b00;
  localparam logic [1:0] HC_STOP = 2'b01;
  localparam logic [1:0] HC_STEP = 2'b10;
  localparam logic [1:0] HC_BRK  = 2'b11;

  localparam logic [STEP_WIDTH-1:0] STEP_ONE = {{(STEP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_t                state, state_nxt;
  logic [1:0]            halt_cause_nxt;
  logic [STEP_WIDTH-1:0] step_rem_nxt;
  logic [CNT_WIDTH-1:0]  exec_cnt_nxt;
  logic                  skip, skip_nxt;
  logic                  cmd_acc, brk_hit;

  assign CMD_READY = ~CRST;
  assign cmd_acc   = CMD_VALID & CMD_READY;
  assign BUSY      = (state != S_IDLE);
  // skip lets the launch instruction execute even when it sits on the breakpoint
  assign brk_hit   = BRK_EN & (REGPC == BRK_ADDR) & ~skip;
  assign CEXEC     = BUSY & ~brk_hit;

  always_comb begin
    state_nxt      = state;
    halt_cause_nxt = HALT_CAUSE;
    step_rem_nxt   = STEP_REM;
    skip_nxt       = skip;
    exec_cnt_nxt   = EXEC_CNT;

    if (CEXEC) begin
      skip_nxt     = 1'b0;
      exec_cnt_nxt = sat_inc(EXEC_CNT);
    end
    if (cmd_acc && CMD_OP == OP_CLRCNT)
      exec_cnt_nxt = '0;

    unique case (state)
      S_IDLE: begin
        if (cmd_acc) begin
          unique case (CMD_OP)
            OP_RUN: begin
              state_nxt      = S_RUN;
              halt_cause_nxt = HC_NONE;
              skip_nxt       = 1'b1;
            end
            OP_STEP: begin
              if (CMD_ARG != '0) begin
                state_nxt      = S_STEP;
                step_rem_nxt   = CMD_ARG;
                halt_cause_nxt = HC_NONE;
                skip_nxt       = 1'b1;
              end else begin
                halt_cause_nxt = HC_STEP;
              end
            end
            OP_STOP:   halt_cause_nxt = HC_STOP;
            OP_CLRCNT: ;
          endcase
        end
      end
      S_RUN: begin
        if (brk_hit) begin
          state_nxt      = S_IDLE;
          halt_cause_nxt = HC_BRK;
        end else if (cmd_acc && CMD_OP == OP_STOP) begin
          state_nxt      = S_IDLE;
          halt_cause_nxt = HC_STOP;
        end
      end
      S_STEP: begin
        if (CEXEC)
          step_rem_nxt = STEP_REM - STEP_ONE;
        // breakpoint > step done > STOP
        if (brk_hit) begin
          state_nxt      = S_IDLE;
          halt_cause_nxt = HC_BRK;
        end else if (CEXEC && STEP_REM == STEP_ONE) begin
          state_nxt      = S_IDLE;
          step_rem_nxt   = '0;
          halt_cause_nxt = HC_STEP;
        end else if (cmd_acc && CMD_OP == OP_STOP) begin
          state_nxt      = S_IDLE;
          halt_cause_nxt = HC_STOP;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CCLK) begin
    if (CRST) begin
      state      <= S_IDLE;
      HALT_CAUSE <= HC_NONE;
      STEP_REM   <= '0;
      EXEC_CNT   <= '0;
      skip       <= 1'b0;
    end else begin
      state      <= state_nxt;
      HALT_CAUSE <= halt_cause_nxt;
      STEP_REM   <= step_rem_nxt;
      EXEC_CNT   <= exec_cnt_nxt;
      skip       <= skip_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_exec_sequencer.sv
// Directed bench for cpu_exec_sequencer with a simple core PC model and a
// narrow-counter instance for saturation.
module tb_cpu_exec_sequencer;

  localparam logic [1:0] OP_STOP = 2'b00, OP_RUN = 2'b01, OP_STEP = 2'b10, OP_CLRCNT = 2'b11;

  logic        clk = 1'b0;
  logic        crst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_arg = '0;
  logic        brk_en = 1'b0;
  logic [31:0] brk_addr = '0;
  logic [31:0] regpc;
  logic        pc_ld = 1'b0;
  logic [31:0] pc_ld_val = '0;

  logic        cmd_ready, cexec, busy;
  logic [1:0]  halt_cause;
  logic [15:0] step_rem;
  logic [31:0] exec_cnt;

  logic        s_ready, s_cexec, s_busy;
  logic [1:0]  s_hc;
  logic [15:0] s_rem;
  logic [3:0]  s_cnt;

  int total = 0;
  int bad   = 0;
  int n;
  int guard;

  always #5 clk = ~clk;

  // core model: PC advances by 4 on each executed cycle
  always @(posedge clk) begin
    if (pc_ld) regpc <= pc_ld_val;
    else if (cexec) regpc <= regpc + 32'd4;
  end

  cpu_exec_sequencer #(.STEP_WIDTH(16), .CNT_WIDTH(32)) u_dut (
    .CCLK(clk), .CRST(crst), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_OP(cmd_op), .CMD_ARG(cmd_arg), .BRK_EN(brk_en), .BRK_ADDR(brk_addr),
    .REGPC(regpc), .CEXEC(cexec), .BUSY(busy), .HALT_CAUSE(halt_cause),
    .STEP_REM(step_rem), .EXEC_CNT(exec_cnt)
  );

  cpu_exec_sequencer #(.STEP_WIDTH(16), .CNT_WIDTH(4)) u_sat (
    .CCLK(clk), .CRST(crst), .CMD_VALID(cmd_valid), .CMD_READY(s_ready),
    .CMD_OP(cmd_op), .CMD_ARG(cmd_arg), .BRK_EN(brk_en), .BRK_ADDR(brk_addr),
    .REGPC(regpc), .CEXEC(s_cexec), .BUSY(s_busy), .HALT_CAUSE(s_hc),
    .STEP_REM(s_rem), .EXEC_CNT(s_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic load_pc(input logic [31:0] v);
    pc_ld     = 1'b1;
    pc_ld_val = v;
    tick();
    pc_ld     = 1'b0;
  endtask

  initial begin
    // reset
    pc_ld = 1'b1; pc_ld_val = 32'h100;
    tick(); tick();
    pc_ld = 1'b0;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_cexec", cexec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hc", halt_cause, 0);
    chk("rst_rem", step_rem, 0);
    chk("rst_cnt", exec_cnt, 0);
    crst = 1'b0;
    #1;
    chk("ready", cmd_ready, 1);

    // STEP 3 from 0x100
    cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_arg = 16'd3;
    #1 chk("step_accept_cexec", cexec, 0);
    tick();
    cmd_valid = 1'b0;
    chk("step_c0", cexec, 1);
    chk("step_pc0", regpc, 32'h100);
    chk("step_rem0", step_rem, 3);
    tick();
    chk("step_c1", cexec, 1);
    chk("step_rem1", step_rem, 2);
    tick();
    chk("step_c2", cexec, 1);
    chk("step_busy2", busy, 1);
    tick();
    chk("step_busy_fall", busy, 0);
    chk("step_c3", cexec, 0);
    chk("step_hc", halt_cause, 2'b10);
    chk("step_rem_end", step_rem, 0);
    chk("step_cnt", exec_cnt, 3);

    // RUN into breakpoint at 0x110
    brk_en = 1'b1; brk_addr = 32'h110;
    load_pc(32'h100);
    send(OP_RUN, 16'd0);
    n = 0; guard = 0;
    while (busy && guard < 20) begin
      if (cexec) n++;
      else chk("brk_pc", regpc, 32'h110);
      tick();
      guard++;
    end
    chk("brk_timeout", busy, 0);
    chk("brk_execs", n, 4);
    chk("brk_hc", halt_cause, 2'b11);
    chk("brk_cexec", cexec, 0);
    chk("brk_cnt", exec_cnt, 7);

    // RUN again: skip lets 0x110 execute; RUN while running ignored; STOP
    send(OP_RUN, 16'd0);
    chk("skip_cexec", cexec, 1);
    chk("skip_pc", regpc, 32'h110);
    tick();
    chk("rerun_cexec", cexec, 1);
    send(OP_RUN, 16'd0);
    chk("run_ign_busy", busy, 1);
    chk("run_ign_hc", halt_cause, 0);
    cmd_valid = 1'b1; cmd_op = OP_STOP;
    #1 chk("stop_t_cexec", cexec, 1);
    tick();
    cmd_valid = 1'b0;
    chk("stop_t1_cexec", cexec, 0);
    chk("stop_busy", busy, 0);
    chk("stop_hc", halt_cause, 2'b01);
    chk("stop_cnt", exec_cnt, 10);

    // STEP 0 in IDLE
    brk_en = 1'b0;
    send(OP_STEP, 16'd0);
    chk("step0_cexec", cexec, 0);
    chk("step0_busy", busy, 0);
    chk("step0_hc", halt_cause, 2'b10);

    // STEP 5 with breakpoint on the third PC
    brk_en = 1'b1; brk_addr = 32'h208;
    load_pc(32'h200);
    send(OP_STEP, 16'd5);
    n = 0; guard = 0;
    while (busy && guard < 20) begin
      if (cexec) n++;
      tick();
      guard++;
    end
    chk("stepbrk_timeout", busy, 0);
    chk("stepbrk_execs", n, 2);
    chk("stepbrk_hc", halt_cause, 2'b11);
    chk("stepbrk_rem", step_rem, 3);
    chk("stepbrk_cnt", exec_cnt, 12);

    // reset mid-RUN at EXEC_CNT=20
    brk_en = 1'b0;
    send(OP_RUN, 16'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("pre_rst_cnt", exec_cnt, 20);
    chk("pre_rst_busy", busy, 1);
    crst = 1'b1;
    tick();
    chk("mid_rst_cexec", cexec, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", exec_cnt, 0);
    chk("mid_rst_hc", halt_cause, 0);
    crst = 1'b0;

    // CLRCNT during RUN, clear beats the coincident increment
    send(OP_RUN, 16'd0);
    tick(); tick();
    chk("clr_pre", exec_cnt, 2);
    chk("clr_pre_cexec", cexec, 1);
    send(OP_CLRCNT, 16'd0);
    chk("clr_zero", exec_cnt, 0);
    chk("clr_busy", busy, 1);
    tick();
    chk("clr_inc1", exec_cnt, 1);
    tick();
    chk("clr_inc2", exec_cnt, 2);

    // 4-bit counter saturates at 15
    for (int i = 0; i < 16; i++) tick();
    chk("sat_15", s_cnt, 4'hF);
    tick(); tick();
    chk("sat_hold", s_cnt, 4'hF);
    chk("wide_cnt", exec_cnt, 20);
    send(OP_STOP, 16'd0);
    chk("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
